// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths and result-entry type for the ALU, issue stage and result buffer
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int SEQ_W  = 4;

  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic [DATA_W-1:0] data;
  } alu_res_t;

endpackage

// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - captures ALU results into a tagged FIFO with valid/ready output
// and drop detection, since the ALU itself cannot be stalled.
module alu_result_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int SEQ_W  = alu_pkg::SEQ_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       res_valid,
  input  logic [DATA_W-1:0]          res_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [SEQ_W-1:0]           out_seq,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full,
  output logic                       overflow,
  input  logic                       clr_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - 1);

  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [DATA_W-1:0] mem_data_d [DEPTH];
  logic [SEQ_W-1:0]  mem_seq_q  [DEPTH];
  logic [SEQ_W-1:0]  mem_seq_d  [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SEQ_W-1:0] seq_ctr_q, seq_ctr_d;
  logic             overflow_q, overflow_d;

  logic push, pop, drop, full;

  always_comb begin
    full = (count_q == FULL_CNT);
    pop  = (count_q != '0) && out_ready;
    // A pop in the same cycle frees the slot, so a full buffer can still accept.
    push = res_valid && (!full || pop);
    drop = res_valid && full && !pop;
  end

  always_comb begin
    mem_data_d = mem_data_q;
    mem_seq_d  = mem_seq_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    seq_ctr_d  = seq_ctr_q;
    overflow_d = overflow_q;

    if (push) begin
      mem_data_d[wr_ptr_q] = res_data;
      mem_seq_d[wr_ptr_q]  = seq_ctr_q;
      wr_ptr_d             = wr_ptr_q + PW'(1);
      seq_ctr_d            = seq_ctr_q + SEQ_W'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    // Setting wins over a simultaneous clear so no drop event is ever lost.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_seq_q[i]  <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      seq_ctr_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_data_q <= mem_data_d;
      mem_seq_q  <= mem_seq_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      seq_ctr_q  <= seq_ctr_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    out_valid   = (count_q != '0);
    out_data    = mem_data_q[rd_ptr_q];
    out_seq     = mem_seq_q[rd_ptr_q];
    count       = count_q;
    almost_full = (count_q >= AF_CNT);
    overflow    = overflow_q;
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - directed scoreboard bench for alu_result_buffer
module tb_alu_result_buffer;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             res_valid = 1'b0;
  logic [DATA_W-1:0] res_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [SEQ_W-1:0] out_seq;
  logic [2:0]       count;
  logic             almost_full;
  logic             overflow;
  logic             clr_ovf = 1'b0;

  int errors = 0;
  int checks = 0;

  alu_res_t         sb[$];
  logic [SEQ_W-1:0] m_seq = '0;
  logic             m_ovf = 1'b0;
  int               delivered = 0;

  alu_result_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid), .res_data(res_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_seq(out_seq), .count(count), .almost_full(almost_full),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check head before the edge, update model, check state after.
  task automatic step(input logic rv, input logic [DATA_W-1:0] d, input logic rr, input logic clr);
    bit m_pop, m_push, m_drop;
    alu_res_t e;
    @(negedge clk);
    res_valid = rv; res_data = d; out_ready = rr; clr_ovf = clr;
    #1;
    check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("out_data", 32'(out_data), 32'(sb[0].data));
      check("out_seq", 32'(out_seq), 32'(sb[0].seq));
    end
    m_pop  = (sb.size() != 0) && rr;
    m_push = rv && ((sb.size() < DEPTH) || m_pop);
    m_drop = rv && (sb.size() == DEPTH) && !m_pop;
    if (m_pop) begin
      void'(sb.pop_front());
      delivered++;
    end
    if (m_push) begin
      e.seq = m_seq; e.data = d;
      sb.push_back(e);
      m_seq = m_seq + 1'b1;
    end
    if (m_drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge clk);
    #1;
    check("count", 32'(count), 32'(sb.size()));
    check("almost_full", 32'(almost_full), 32'(sb.size() >= DEPTH - 1));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    res_valid = 1'b0; out_ready = 1'b0; clr_ovf = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_almost_full", 32'(almost_full), 32'd0);
    sb.delete();
    m_seq = '0;
    m_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int sent;
    int cyc;
    #1;
    check("por_out_data", 32'(out_data), 32'd0);
    check("por_out_seq", 32'(out_seq), 32'd0);
    check("por_count", 32'(count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Three results with no consumer, then drain in order.
    step(1'b1, 8'h08, 1'b0, 1'b0);
    step(1'b1, 8'h07, 1'b0, 1'b0);
    step(1'b1, 8'h18, 1'b0, 1'b0);
    check("head_after3", 32'({out_seq, out_data}), 32'({4'd0, 8'h08}));
    check("af_after3", 32'(almost_full), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    check("drained_valid", 32'(out_valid), 32'd0);

    // Fill from a fresh reset, then force a drop.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    check("drop_ovf", 32'(overflow), 32'd1);
    check("drop_count", 32'(count), 32'd4);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_ovf", 32'(overflow), 32'd0);

    // Full with simultaneous push and pop: next accepted entry carries seq 4.
    step(1'b1, 8'h61, 1'b1, 1'b0);
    check("full_pp_count", 32'(count), 32'd4);
    check("full_pp_ovf", 32'(overflow), 32'd0);
    check("seq_after_drop", 32'(sb[DEPTH-1].seq), 32'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Twenty throttled results with a toggling consumer; seq wraps past 15.
    sent = 0;
    cyc = 0;
    delivered = 0;
    while ((sent < 20 || sb.size() != 0) && cyc < 400) begin
      if (sent < 20 && !almost_full) begin
        step(1'b1, 8'(8'h30 + sent), 1'(cyc % 2), 1'b0);
        sent++;
      end else begin
        step(1'b0, 8'h00, 1'(cyc % 2), 1'b0);
      end
      cyc++;
    end
    check("stream_delivered", 32'(delivered), 32'd20);
    check("stream_no_ovf", 32'(overflow), 32'd0);
    check("stream_seq_wrapped", 32'(m_seq), 32'd9);

    // Reset with two entries held and overflow set.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("pre_rst_count", 32'(count), 32'd2);
    do_reset();
    step(1'b1, 8'h99, 1'b0, 1'b0);
    check("post_rst_seq", 32'(out_seq), 32'd0);
    check("post_rst_data", 32'(out_data), 32'h99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
